// File: rtl/rom_pkg.sv
// Shared constants and width helpers for the multi-channel ROM arbiter.
package rom_pkg;

  localparam int MAX_CH = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Channel-index width; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_arb_if.sv
// Request/response bundle between fetch clients (master) and rom_arb (slave).
// rsp_addr exists only when ROM_ARB_RSP_ADDR_EN is defined.
interface rom_arb_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CH-1:0]            req_ready;
  logic [NUM_CH-1:0]            rsp_valid;
  logic [NUM_CH-1:0]            rsp_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] rsp_data;
`ifdef ROM_ARB_RSP_ADDR_EN
  logic [NUM_CH*ADDR_WIDTH-1:0] rsp_addr;
`endif

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
`ifdef ROM_ARB_RSP_ADDR_EN
    , input rsp_addr
`endif
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
`ifdef ROM_ARB_RSP_ADDR_EN
    , output rsp_addr
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req searching upward from ptr+1.
// The pointer register is owned by the caller.
module rr_arbiter
  import rom_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int c;
    c         = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any_grant && req[c]) begin
        any_grant = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rom_arb.sv
// NUM_CH-channel synchronous ROM sharing one block-RAM read port; rsp_valid two cycles after accept.
// ROM_ARB_RSP_ADDR_EN adds rsp_addr, the accepted address held alongside each response word.
module rom_arb
  import rom_pkg::*;
#(
  parameter int    ADDR_WIDTH = 9,
  parameter int    DATA_WIDTH = 8,
  parameter int    NUM_CH     = 2,
  parameter string FILE_NAME  = "",
  parameter int    INIT       = 0
) (
  input logic      clk,
  input logic      rst_n,
  rom_arb_if.slave bus
);

  localparam int IW    = idx_w(NUM_CH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("rom_arb: NUM_CH out of range");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q;

  logic [IW-1:0]                        ptr_q, ptr_d;
  logic                                 inflight_v_q, inflight_v_d;
  logic [IW-1:0]                        inflight_ch_q, inflight_ch_d;
  logic [NUM_CH-1:0]                    rsp_valid_q, rsp_valid_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    slot_q, slot_d;
`ifdef ROM_ARB_RSP_ADDR_EN
  logic [ADDR_WIDTH-1:0]                inflight_addr_q, inflight_addr_d;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    rsp_addr_q, rsp_addr_d;
`endif

  logic [NUM_CH-1:0]     elig, grant;
  logic [IW-1:0]         grant_idx;
  logic                  any_grant;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // A channel with a read in flight, or a stalled full slot, sits this cycle out.
  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = bus.req_valid[c]
              && !(inflight_v_q && inflight_ch_q == IW'(c))
              && (!rsp_valid_q[c] || bus.rsp_ready[c]);
    end
  end

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req       (elig),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) rd_addr = bus.req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (any_grant) mem_q <= mem[rd_addr];
  end

  always_comb begin
    ptr_d         = any_grant ? grant_idx : ptr_q;
    inflight_v_d  = any_grant;
    inflight_ch_d = any_grant ? grant_idx : inflight_ch_q;
    rsp_valid_d   = rsp_valid_q & ~bus.rsp_ready;
    slot_d        = slot_q;
`ifdef ROM_ARB_RSP_ADDR_EN
    inflight_addr_d = any_grant ? rd_addr : inflight_addr_q;
    rsp_addr_d      = rsp_addr_q;
`endif
    // Landing word overrides a same-edge pop.
    if (inflight_v_q) begin
      rsp_valid_d[inflight_ch_q] = 1'b1;
      slot_d[inflight_ch_q]      = mem_q;
`ifdef ROM_ARB_RSP_ADDR_EN
      rsp_addr_d[inflight_ch_q]  = inflight_addr_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q           <= IW'(NUM_CH - 1);
      inflight_v_q    <= 1'b0;
      inflight_ch_q   <= '0;
      rsp_valid_q     <= '0;
      slot_q          <= '0;
`ifdef ROM_ARB_RSP_ADDR_EN
      inflight_addr_q <= '0;
      rsp_addr_q      <= '0;
`endif
    end else begin
      ptr_q           <= ptr_d;
      inflight_v_q    <= inflight_v_d;
      inflight_ch_q   <= inflight_ch_d;
      rsp_valid_q     <= rsp_valid_d;
      slot_q          <= slot_d;
`ifdef ROM_ARB_RSP_ADDR_EN
      inflight_addr_q <= inflight_addr_d;
      rsp_addr_q      <= rsp_addr_d;
`endif
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = slot_q;
`ifdef ROM_ARB_RSP_ADDR_EN
  assign bus.rsp_addr  = rsp_addr_q;
`endif

endmodule

// File: tb/tb_rom_arb.sv
// Randomized bench for rom_arb (3 channels) against a transaction-level model of
// the arbitration and response rules; checks rsp_addr when ROM_ARB_RSP_ADDR_EN is defined.
module tb_rom_arb;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int N     = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_arb_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_CH     (N),
    .FILE_NAME  (""),
    .INIT       (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: image contents, held responses per channel, last accept, rotation point.
  logic [DW-1:0] rom [DEPTH];
  logic [N-1:0]  m_valid;
  logic [DW-1:0] m_data [N];
  logic [AW-1:0] m_addr [N];
  int            m_ptr;
  int            last_g;
  logic [AW-1:0] last_a;
  int            cyc = 0;

  task automatic model_reset();
    m_valid = '0;
    for (int c = 0; c < N; c++) begin
      m_data[c] = '0;
      m_addr[c] = '0;
    end
    m_ptr  = N - 1;
    last_g = -1;
    last_a = '0;
  endtask

  task automatic cycle(input logic [N-1:0] rv, input logic [N-1:0] rr);
    logic [AW-1:0]   a [N];
    logic [N*AW-1:0] flat;
    logic [N-1:0]    exp_rdy;
    logic [N*DW-1:0] exp_dat;
    logic [N*AW-1:0] exp_adr;
    int              g;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      a[c] = AW'($urandom);
      flat[c*AW +: AW] = a[c];
    end
    bus.req_valid = rv;
    bus.req_addr  = flat;
    bus.rsp_ready = rr;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (g < 0 && rv[c] && last_g != c && (!m_valid[c] || rr[c])) g = c;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int c = 0; c < N; c++) begin
      exp_dat[c*DW +: DW] = m_data[c];
      exp_adr[c*AW +: AW] = m_addr[c];
    end
    @(negedge clk);
    chk($sformatf("req_ready@%0d", cyc), 64'(bus.req_ready), 64'(exp_rdy));
    chk($sformatf("rsp_valid@%0d", cyc), 64'(bus.rsp_valid), 64'(m_valid));
    chk($sformatf("rsp_data@%0d", cyc), 64'(bus.rsp_data), 64'(exp_dat));
`ifdef ROM_ARB_RSP_ADDR_EN
    chk($sformatf("rsp_addr@%0d", cyc), 64'(bus.rsp_addr), 64'(exp_adr));
`endif
    // Advance to the state after the coming edge: pop first, a landing word wins.
    for (int c = 0; c < N; c++) begin
      if (m_valid[c] && rr[c]) m_valid[c] = 1'b0;
    end
    if (last_g >= 0) begin
      m_valid[last_g] = 1'b1;
      m_data[last_g]  = rom[last_a];
      m_addr[last_g]  = last_a;
    end
    last_g = g;
    if (g >= 0) begin
      last_a = a[g];
      m_ptr  = g;
    end
    cyc++;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rom[i]     = DW'($urandom);
      dut.mem[i] = rom[i];
    end
    model_reset();
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_rsp_data", 64'(bus.rsp_data), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Everyone requesting and draining: strict rotation, one accept per cycle.
    repeat (30) cycle('1, '1);
    // ch1 stalls its consumer; it must hold its word while the others rotate.
    repeat (25) cycle('1, 3'b101);
    repeat (15) cycle('1, '1);
    // Single requester with a drained slot: every-other-cycle accepts.
    repeat (12) cycle(3'b001, '1);
    repeat (300) cycle(N'($urandom), N'($urandom));

    // Asynchronous reset one cycle after a grant: held state vanishes at once.
    cycle('1, '1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("async_rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) cycle('1, '1);
    repeat (200) cycle(N'($urandom), N'($urandom | 32'h2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
